lcd_msg_arbiter: RTL and testbench

- Shares the single 2x16 character LCD between two message sources (for example a status source and an alert source).
- Each source presents a two-line, 128-bit-per-line ASCII message with a req/ack handshake.
- The block grants round-robin, latches the winner's message into the line registers that feed lcd_driver, and pulses an update strobe.
- It then holds the message for a minimum display time before accepting another request.

---
 rtl/lcd_pkg.sv | 14 +
 rtl/lcd_msg_arbiter_hold_timer.sv | 37 +++
 rtl/lcd_msg_arbiter.sv | 123 ++++++++++++
 tb/tb_lcd_msg_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD message arbiter.
package lcd_pkg;

  localparam int LINE_W    = 128;
  localparam int LCD_CHARS = 16;

  localparam logic [LINE_W-1:0] BLANK_LINE = {LCD_CHARS{8'h20}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/lcd_msg_arbiter_hold_timer.sv
// Minimum-display-time counter: start clears and arms it, expire flags the
// last cycle of the hold window.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             run_reg;

  assign expire = run_reg && (cnt_reg == LAST_CNT);

  // Counting stops at expire so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      cnt_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (expire) begin
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one 2x16 LCD between two message sources, with
// a minimum hold time per granted message.
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int                HOLD_CYCLES = 50_000_000,
  parameter int                CNT_W       = 26,
  parameter logic [LINE_W-1:0] DEF_L1      = BLANK_LINE,
  parameter logic [LINE_W-1:0] DEF_L2      = BLANK_LINE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [LINE_W-1:0] msg0_l1,
  input  logic [LINE_W-1:0] msg0_l2,
  input  logic              req1,
  input  logic [LINE_W-1:0] msg1_l1,
  input  logic [LINE_W-1:0] msg1_l2,
  output logic              ack0,
  output logic              ack1,
  output logic              busy,
  output logic              owner,
  output logic [LINE_W-1:0] lcd_l1,
  output logic [LINE_W-1:0] lcd_l2,
  output logic              lcd_upd
);

  state_t            state_reg, state_next;
  logic              rr_reg, rr_next;
  logic              owner_reg, owner_next;
  logic              ack0_reg, ack0_next;
  logic              ack1_reg, ack1_next;
  logic              upd_reg, upd_next;
  logic              paint_reg;
  logic [LINE_W-1:0] l1_reg, l1_next;
  logic [LINE_W-1:0] l2_reg, l2_next;
  logic              grant;
  logic              winner;
  logic              expire;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (grant),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rr_reg    <= 1'b0;
      owner_reg <= 1'b0;
      ack0_reg  <= 1'b0;
      ack1_reg  <= 1'b0;
      upd_reg   <= 1'b0;
      paint_reg <= 1'b1;
      l1_reg    <= DEF_L1;
      l2_reg    <= DEF_L2;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      owner_reg <= owner_next;
      ack0_reg  <= ack0_next;
      ack1_reg  <= ack1_next;
      upd_reg   <= upd_next;
      paint_reg <= 1'b0;
      l1_reg    <= l1_next;
      l2_reg    <= l2_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    owner_next = owner_reg;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    // The first edge out of reset repaints the default text.
    upd_next   = paint_reg;
    l1_next    = l1_reg;
    l2_next    = l2_reg;
    grant      = 1'b0;
    winner     = rr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant  = 1'b1;
          winner = (req0 && req1) ? rr_reg : req1;
        end
      end
      ST_HOLD: begin
        if (expire) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (grant) begin
      state_next = ST_HOLD;
      rr_next    = ~winner;
      owner_next = winner;
      ack0_next  = ~winner;
      ack1_next  = winner;
      upd_next   = 1'b1;
      l1_next    = winner ? msg1_l1 : msg0_l1;
      l2_next    = winner ? msg1_l2 : msg0_l2;
    end
  end

  assign ack0    = ack0_reg;
  assign ack1    = ack1_reg;
  assign busy    = (state_reg == ST_HOLD);
  assign owner   = owner_reg;
  assign lcd_l1  = l1_reg;
  assign lcd_l2  = l2_reg;
  assign lcd_upd = upd_reg;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Randomized bench for lcd_msg_arbiter: two instances (hold 4 and hold 1)
// share stimulus and are each compared every cycle with a behavioural model.
module tb_lcd_msg_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [127:0] msg0_l1, msg0_l2, msg1_l1, msg1_l2;

  logic         a0_4, a1_4, busy_4, own_4, upd_4;
  logic [127:0] l1_4, l2_4;
  logic         a0_1, a1_1, busy_1, own_1, upd_1;
  logic [127:0] l1_1, l2_1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  lcd_msg_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .msg0_l1(msg0_l1), .msg0_l2(msg0_l2),
    .req1(req1), .msg1_l1(msg1_l1), .msg1_l2(msg1_l2),
    .ack0(a0_4), .ack1(a1_4), .busy(busy_4), .owner(own_4),
    .lcd_l1(l1_4), .lcd_l2(l2_4), .lcd_upd(upd_4)
  );

  lcd_msg_arbiter #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .msg0_l1(msg0_l1), .msg0_l2(msg0_l2),
    .req1(req1), .msg1_l1(msg1_l1), .msg1_l2(msg1_l2),
    .ack0(a0_1), .ack1(a1_1), .busy(busy_1), .owner(own_1),
    .lcd_l1(l1_1), .lcd_l2(l2_1), .lcd_upd(upd_1)
  );

  // Reference model: hold tracked as cycles remaining in the display window.
  typedef struct {
    logic [127:0] l1, l2;
    logic ack0, ack1, upd, busy, owner, rr, first;
    int   remaining;
  } mdl_t;

  mdl_t m4, m1;

  function automatic mdl_t step(mdl_t m, int hold);
    mdl_t n;
    int   w;
    n = m;
    if (!rst_n) begin
      n.l1 = {16{8'h20}};
      n.l2 = {16{8'h20}};
      n.ack0 = 0; n.ack1 = 0; n.upd = 0; n.busy = 0;
      n.owner = 0; n.rr = 0; n.first = 1; n.remaining = 0;
      return n;
    end
    n.ack0 = 0;
    n.ack1 = 0;
    n.upd = m.first;
    n.first = 0;
    if (m.remaining > 0) begin
      n.remaining = m.remaining - 1;
      n.busy = (n.remaining > 0);
    end else if (req0 || req1) begin
      if (req0 && req1) w = m.rr ? 1 : 0;
      else w = req1 ? 1 : 0;
      n.l1 = (w == 1) ? msg1_l1 : msg0_l1;
      n.l2 = (w == 1) ? msg1_l2 : msg0_l2;
      n.ack0 = (w == 0);
      n.ack1 = (w == 1);
      n.upd = 1;
      n.owner = (w == 1);
      n.rr = (w == 0);
      n.busy = 1;
      n.remaining = hold;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_dut(input string who, input mdl_t e,
                           input logic a0, input logic a1, input logic b,
                           input logic o, input logic u,
                           input logic [127:0] l1, input logic [127:0] l2);
    chk({who, ".ack0"}, 128'(a0), 128'(e.ack0));
    chk({who, ".ack1"}, 128'(a1), 128'(e.ack1));
    chk({who, ".busy"}, 128'(b), 128'(e.busy));
    chk({who, ".owner"}, 128'(o), 128'(e.owner));
    chk({who, ".upd"}, 128'(u), 128'(e.upd));
    chk({who, ".l1"}, l1, e.l1);
    chk({who, ".l2"}, l2, e.l2);
  endtask

  task automatic tick();
    @(posedge clk);
    m4 = step(m4, 4);
    m1 = step(m1, 1);
    #1;
    cyc++;
    check_dut("h4", m4, a0_4, a1_4, busy_4, own_4, upd_4, l1_4, l2_4);
    check_dut("h1", m1, a0_1, a1_1, busy_1, own_1, upd_1, l1_1, l2_1);
  endtask

  // Drop each request on the cycle the hold-4 instance acks it, within a budget.
  task automatic run_until_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (m4.ack0) req0 = 0;
      if (m4.ack1) req1 = 0;
      done = !req0 && !req1;
    end
    if (!done) chk("ack_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] welcome, kanpur, blank;

  initial begin
    welcome = "WELCOME TO CSE, ";
    kanpur  = "IIT KANPUR      ";
    blank   = {16{8'h20}};
    m4 = '{l1: 0, l2: 0, ack0: 0, ack1: 0, upd: 0, busy: 0, owner: 0, rr: 0, first: 1, remaining: 0};
    m1 = m4;
    rst_n = 0; req0 = 0; req1 = 0;
    msg0_l1 = rnd128(); msg0_l2 = rnd128(); msg1_l1 = rnd128(); msg1_l2 = rnd128();

    // Reset held three cycles, then the default paint.
    repeat (3) tick();
    chk("rst_l1", l1_4, blank);
    rst_n = 1;
    tick();
    chk("paint_upd", 128'(upd_4), 128'(1));

    // Single source 0 request.
    msg0_l1 = welcome; msg0_l2 = kanpur; req0 = 1;
    run_until_idle(10);
    chk("welcome_l1", l1_4, welcome);
    repeat (6) tick();

    // Simultaneous requests, both held until acked.
    msg1_l1 = rnd128(); msg1_l2 = rnd128();
    req0 = 1; req1 = 1;
    run_until_idle(20);
    repeat (6) tick();

    // Source 1 arrives mid-hold and changes its message before grant.
    req0 = 1;
    run_until_idle(10);
    req1 = 1;
    tick();
    msg1_l1 = rnd128();
    run_until_idle(20);
    chk("late_msg1", l1_4, msg1_l1);
    repeat (6) tick();

    // Reset two cycles into a hold, then normal operation resumes.
    req0 = 1;
    run_until_idle(10);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    req1 = 1;
    run_until_idle(10);
    repeat (6) tick();

    // Both held continuously: hold-1 instance alternates every 2 cycles.
    req0 = 1; req1 = 1;
    repeat (12) tick();
    req0 = 0; req1 = 0;
    repeat (6) tick();

    // Random phase: arbitrary request levels, messages and occasional reset.
    for (int i = 0; i < 800; i++) begin
      req0  = ($urandom_range(0, 99) < 40);
      req1  = ($urandom_range(0, 99) < 40);
      rst_n = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 3) == 0) begin
        msg0_l1 = rnd128(); msg0_l2 = rnd128();
      end
      if ($urandom_range(0, 3) == 0) begin
        msg1_l1 = rnd128(); msg1_l2 = rnd128();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
